// File: rtl/bitstream_word_packer.sv
// Packs MSB-aligned variable-length bit fields into a contiguous stream of
// 128-bit words, MSB first; a flush drains the residue as a padded final word.
module bitstream_word_packer (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [125:0] i_bv,
  input  logic [6:0]   i_bc,
  input  logic         i_flush,
  output logic         i_rdy,
  output logic         o_en,
  output logic [127:0] o_data,
  output logic         o_last,
  output logic [4:0]   o_nbytes
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t       r_state, w_state_nxt;
  logic [255:0] r_buf, w_buf_nxt, w_merged;
  logic [7:0]   r_cnt, w_cnt_nxt, w_sum, w_len;
  logic [6:0]   w_bc;
  logic [125:0] w_mask, w_bv_m;
  logic [8:0]   w_round;
  logic         w_en_nxt, w_last_nxt;
  logic [127:0] w_data_nxt;
  logic [4:0]   w_nbytes_nxt;

  assign i_rdy = (r_state == RUN);

  // An idle cycle merges zero bits, so flush-without-data shares the same path.
  assign w_bc     = !i_en ? 7'd0 : ((i_bc > 7'd126) ? 7'd126 : i_bc);
  assign w_mask   = ~({126{1'b1}} >> w_bc);
  assign w_bv_m   = i_bv & w_mask;
  assign w_merged = r_buf | ({w_bv_m, 130'b0} >> r_cnt);
  assign w_sum    = r_cnt + {1'b0, w_bc};
  assign w_len    = (r_state == DRAIN) ? r_cnt : w_sum;
  assign w_round  = {1'b0, w_len} + 9'd7;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_cnt_nxt    = r_cnt;
    w_en_nxt     = 1'b0;
    w_last_nxt   = 1'b0;
    w_data_nxt   = o_data;
    w_nbytes_nxt = o_nbytes;
    case (r_state)
      DRAIN: begin
        w_en_nxt     = 1'b1;
        w_data_nxt   = r_buf[255:128];
        w_last_nxt   = 1'b1;
        w_nbytes_nxt = w_round[7:3];
        w_buf_nxt    = '0;
        w_cnt_nxt    = '0;
        w_state_nxt  = RUN;
      end
      RUN: begin
        if (i_flush) begin
          w_en_nxt   = 1'b1;
          w_data_nxt = w_merged[255:128];
          if (w_sum > 8'd128) begin
            w_last_nxt   = 1'b0;
            w_nbytes_nxt = 5'd16;
            w_buf_nxt    = w_merged << 128;
            w_cnt_nxt    = w_sum - 8'd128;
            w_state_nxt  = DRAIN;
          end else begin
            w_last_nxt   = 1'b1;
            w_nbytes_nxt = w_round[7:3];
            w_buf_nxt    = '0;
            w_cnt_nxt    = '0;
          end
        end else if (w_sum >= 8'd128) begin
          w_en_nxt     = 1'b1;
          w_data_nxt   = w_merged[255:128];
          w_nbytes_nxt = 5'd16;
          w_buf_nxt    = w_merged << 128;
          w_cnt_nxt    = w_sum - 8'd128;
        end else begin
          w_buf_nxt = w_merged;
          w_cnt_nxt = w_sum;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_buf    <= '0;
      r_cnt    <= '0;
      o_en     <= 1'b0;
      o_data   <= '0;
      o_last   <= 1'b0;
      o_nbytes <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_buf    <= w_buf_nxt;
      r_cnt    <= w_cnt_nxt;
      o_en     <= w_en_nxt;
      o_data   <= w_data_nxt;
      o_last   <= w_last_nxt;
      o_nbytes <= w_nbytes_nxt;
    end
  end

endmodule
